// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - SECDED code geometry helpers and decode status type
package secded_pkg;

    // Widest check field over the legal DATA_W range (128 data bits -> 8 + overall)
    localparam int MAX_CHK_W = 9;

    typedef struct packed {
        logic                 sgl;
        logic                 dbl;
        logic [MAX_CHK_W-1:0] syn;
    } dec_status_t;

    function automatic bit is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic int chk_w(input int data_w);
        int r;
        r = 1;
        for (int k = 8; k >= 1; k--) begin
            if ((1 << k) >= data_w + k + 1) r = k;
        end
        return r + 1;
    endfunction

    // Hamming position (1-based) carrying data bit idx
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 1; p < 256; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/secded_parity.sv
// rtl/secded_parity.sv - Hamming parity groups plus overall parity of a codeword vector
module secded_parity #(
    parameter int CW_W = 39,
    parameter int R    = 6
) (
    input  logic [CW_W-1:0] cw,
    output logic [R-1:0]    ham,
    output logic            par
);

    // Group k covers every position whose binary index has bit k set
    always_comb begin
        ham = '0;
        for (int k = 0; k < R; k++) begin
            for (int i = 0; i < CW_W - 1; i++) begin
                if ((((i + 1) >> k) % 2) == 1) ham[k] = ham[k] ^ cw[i];
            end
        end
    end

    assign par = ^cw;

endmodule

// File: rtl/secded_codec_pipe.sv
// rtl/secded_codec_pipe.sv - pipelined SECDED encoder (1 stage) and decoder (2 stages)
module secded_codec_pipe
    import secded_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int CNT_W  = 16,
    localparam int CHK_W  = chk_w(DATA_W),
    localparam int CW_W   = DATA_W + CHK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [DATA_W-1:0] enc_data,
    input  logic [CW_W-1:0]   enc_inj,
    output logic              enc_out_valid,
    input  logic              enc_out_ready,
    output logic [CW_W-1:0]   enc_cw,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [CW_W-1:0]   dec_cw,
    output logic              dec_out_valid,
    input  logic              dec_out_ready,
    output logic [DATA_W-1:0] dec_data,
    output logic [CHK_W-1:0]  dec_syn,
    output logic              dec_err,
    output logic              dec_sgl,
    output logic              dec_dbl,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sgl_cnt,
    output logic [CNT_W-1:0]  dbl_cnt
);

    localparam int               R       = CHK_W - 1;
    localparam logic [R-1:0]     MAX_POS = R'(CW_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CW_W-1:0] enc_raw;
    logic [CW_W-1:0] enc_word;
    logic [R-1:0]    enc_ham;
    logic            enc_par;

    for (genvar i = 0; i < CW_W; i++) begin : g_enc_zero
        if (i == CW_W - 1 || is_pow2(i + 1)) begin : g_z
            assign enc_raw[i] = 1'b0;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_enc_place
        assign enc_raw[data_pos(j) - 1] = enc_data[j];
    end

    secded_parity #(.CW_W(CW_W), .R(R)) u_enc_par (
        .cw  (enc_raw),
        .ham (enc_ham),
        .par (enc_par)
    );

    for (genvar i = 0; i < CW_W - 1; i++) begin : g_enc_word
        if (is_pow2(i + 1)) begin : g_chk
            assign enc_word[i] = enc_ham[$clog2(i + 1)];
        end else begin : g_dat
            assign enc_word[i] = enc_raw[i];
        end
    end
    // Overall parity = data parity (from zeroed-check vector) folded with the check bits
    assign enc_word[CW_W-1] = enc_par ^ (^enc_ham);

    assign enc_ready = !enc_out_valid || enc_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_out_valid <= 1'b0;
            enc_cw        <= '0;
        end else if (enc_ready) begin
            enc_out_valid <= enc_valid;
            if (enc_valid) enc_cw <= enc_word ^ enc_inj;
        end
    end

    logic [R-1:0]      dec_ham;
    logic              dec_par;
    logic [DATA_W-1:0] dec_cw_data;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_syn;
    logic              s1_adv;
    logic              s2_adv;

    secded_parity #(.CW_W(CW_W), .R(R)) u_dec_par (
        .cw  (dec_cw),
        .ham (dec_ham),
        .par (dec_par)
    );

    // Check bits are fully summarised by the syndrome, so S1 keeps only data bits
    for (genvar j = 0; j < DATA_W; j++) begin : g_dec_pick
        assign dec_cw_data[j] = dec_cw[data_pos(j) - 1];
    end

    assign s2_adv    = !dec_out_valid || dec_out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign dec_ready = s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
        end else if (s1_adv) begin
            s1_valid <= dec_valid;
            if (dec_valid) begin
                s1_data <= dec_cw_data;
                s1_syn  <= {dec_par, dec_ham};
            end
        end
    end

    logic [R-1:0]      syn_s;
    logic              syn_p;
    dec_status_t       cls;
    logic [DATA_W-1:0] data_fix;

    assign syn_s = s1_syn[R-1:0];
    assign syn_p = s1_syn[R];

    always_comb begin
        cls     = '0;
        cls.syn = MAX_CHK_W'(s1_syn);
        if (syn_p) begin
            if (syn_s > MAX_POS) cls.dbl = 1'b1;
            else                 cls.sgl = 1'b1;
        end else if (syn_s != '0) begin
            cls.dbl = 1'b1;
        end
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_dec_fix
        localparam logic [R-1:0] POS = R'(data_pos(j));
        assign data_fix[j] = s1_data[j] ^ (cls.sgl && (syn_s == POS));
    end

    dec_status_t s2_st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_out_valid <= 1'b0;
            dec_data      <= '0;
            s2_st         <= '0;
        end else if (s2_adv) begin
            dec_out_valid <= s1_valid;
            if (s1_valid) begin
                dec_data <= data_fix;
                s2_st    <= cls;
            end
        end
    end

    logic unused_syn_hi;
    assign unused_syn_hi = ^s2_st.syn;

    assign dec_syn = s2_st.syn[CHK_W-1:0];
    assign dec_sgl = s2_st.sgl;
    assign dec_dbl = s2_st.dbl;
    assign dec_err = s2_st.sgl | s2_st.dbl;

    logic dec_acc;
    assign dec_acc = dec_out_valid && dec_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgl_cnt <= '0;
            dbl_cnt <= '0;
        end else begin
            if (cnt_clr)                                      sgl_cnt <= (dec_acc && dec_sgl) ? CNT_W'(1) : '0;
            else if (dec_acc && dec_sgl && sgl_cnt != CNT_MAX) sgl_cnt <= sgl_cnt + CNT_W'(1);
            if (cnt_clr)                                      dbl_cnt <= (dec_acc && dec_dbl) ? CNT_W'(1) : '0;
            else if (dec_acc && dec_dbl && dbl_cnt != CNT_MAX) dbl_cnt <= dbl_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_secded_codec_pipe.sv
// tb/tb_secded_codec_pipe.sv - self-checking bench for secded_codec_pipe (DATA_W=32, CNT_W=2)
module tb_secded_codec_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enc_valid = 1'b0, enc_ready, enc_out_valid, enc_out_ready = 1'b1;
    logic [31:0] enc_data = '0;
    logic [38:0] enc_inj = '0, enc_cw;
    logic        dec_valid = 1'b0, dec_ready, dec_out_valid, dec_out_ready = 1'b1;
    logic [38:0] dec_cw = '0;
    logic [31:0] dec_data;
    logic [6:0]  dec_syn;
    logic        dec_err, dec_sgl, dec_dbl;
    logic        cnt_clr = 1'b0;
    logic [1:0]  sgl_cnt, dbl_cnt;

    always #5 clk = ~clk;

    secded_codec_pipe #(.DATA_W(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data), .enc_inj(enc_inj),
        .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready), .enc_cw(enc_cw),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_cw(dec_cw),
        .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready), .dec_data(dec_data),
        .dec_syn(dec_syn), .dec_err(dec_err), .dec_sgl(dec_sgl), .dec_dbl(dec_dbl),
        .cnt_clr(cnt_clr), .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [6:0]  syn;
        logic        sgl;
        logic        dbl;
    } dres_t;

    // Reference: check bits chosen so the XOR of all set positions is zero
    function automatic logic [38:0] m_encode(input logic [31:0] d);
        logic [38:0] cw;
        int x, j;
        cw = '0; x = 0; j = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                if (d[j]) x = x ^ p;
                j++;
            end
        end
        for (int k = 0; k < 6; k++) cw[(1 << k) - 1] = x[k];
        cw[38] = ^cw[37:0];
        return cw;
    endfunction

    function automatic dres_t m_decode(input logic [38:0] cw);
        dres_t r;
        int s, j;
        logic par;
        logic [38:0] c;
        s = 0;
        for (int p = 1; p <= 38; p++) if (cw[p-1]) s = s ^ p;
        par = ^cw;
        c = cw;
        r.sgl = par && (s <= 38);
        r.dbl = (par && (s > 38)) || (!par && (s != 0));
        if (r.sgl && s != 0) c[s-1] = ~c[s-1];
        r.d = '0; j = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                r.d[j] = c[p-1];
                j++;
            end
        end
        r.syn = {par, 6'(s)};
        return r;
    endfunction

    // Scoreboard, stall-stability and counter model, sampled on the falling edge
    logic [38:0] eq[$];
    dres_t       dq[$];
    int          m_sgl = 0, m_dbl = 0;
    logic        enc_hold = 1'b0, dec_hold = 1'b0;
    logic [38:0] enc_cw_s;
    dres_t       dec_s;

    always @(negedge clk) begin
        dres_t e;
        logic inc_s, inc_d;
        if (rst) begin
            eq.delete(); dq.delete();
            m_sgl = 0; m_dbl = 0;
            enc_hold = 1'b0; dec_hold = 1'b0;
        end else begin
            chk("sgl_cnt", sgl_cnt, m_sgl);
            chk("dbl_cnt", dbl_cnt, m_dbl);
            if (enc_hold) chk("enc_stall_hold", {enc_out_valid, enc_cw}, {1'b1, enc_cw_s});
            if (dec_hold) chk("dec_stall_hold", {dec_out_valid, dec_data, dec_syn, dec_sgl, dec_dbl},
                              {1'b1, dec_s.d, dec_s.syn, dec_s.sgl, dec_s.dbl});
            if (enc_out_valid && enc_out_ready) begin
                if (eq.size() == 0) chk("enc_unexpected_out", 1, 0);
                else chk("enc_cw", enc_cw, eq.pop_front());
            end
            if (enc_valid && enc_ready) eq.push_back(m_encode(enc_data) ^ enc_inj);
            inc_s = 1'b0; inc_d = 1'b0;
            if (dec_out_valid && dec_out_ready) begin
                if (dq.size() == 0) chk("dec_unexpected_out", 1, 0);
                else begin
                    e = dq.pop_front();
                    chk("dec_data", dec_data, e.d);
                    chk("dec_syn", dec_syn, e.syn);
                    chk("dec_sgl", dec_sgl, e.sgl);
                    chk("dec_dbl", dec_dbl, e.dbl);
                    chk("dec_err", dec_err, e.sgl | e.dbl);
                    inc_s = e.sgl; inc_d = e.dbl;
                end
            end
            if (dec_valid && dec_ready) dq.push_back(m_decode(dec_cw));
            if (cnt_clr) m_sgl = inc_s ? 1 : 0; else if (inc_s && m_sgl < 3) m_sgl++;
            if (cnt_clr) m_dbl = inc_d ? 1 : 0; else if (inc_d && m_dbl < 3) m_dbl++;
            enc_hold = enc_out_valid && !enc_out_ready;
            enc_cw_s = enc_cw;
            dec_hold = dec_out_valid && !dec_out_ready;
            dec_s.d = dec_data; dec_s.syn = dec_syn; dec_s.sgl = dec_sgl; dec_s.dbl = dec_dbl;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic enc_one(input logic [31:0] d, input logic [38:0] inj, output logic [38:0] got);
        enc_data = d; enc_inj = inj; enc_valid = 1'b1; enc_out_ready = 1'b1;
        #1;
        chk("enc_ready", enc_ready, 1);
        cycle();
        enc_valid = 1'b0;
        #1;
        chk("enc_lat1_valid", enc_out_valid, 1);
        got = enc_cw;
        cycle();
    endtask

    task automatic dec_one(input logic [38:0] cw, output dres_t got);
        dec_cw = cw; dec_valid = 1'b1; dec_out_ready = 1'b1;
        #1;
        chk("dec_ready", dec_ready, 1);
        cycle();
        dec_valid = 1'b0;
        #1;
        chk("dec_lat1_empty", dec_out_valid, 0);
        cycle();
        chk("dec_lat2_valid", dec_out_valid, 1);
        got.d = dec_data; got.syn = dec_syn; got.sgl = dec_sgl; got.dbl = dec_dbl;
        cycle();
    endtask

    typedef struct { logic [31:0] d; logic [38:0] inj; logic [38:0] cw; } evec_t;
    typedef struct { logic [38:0] cw; logic [31:0] d; logic [6:0] syn; logic sgl; logic dbl; } dvec_t;

    evec_t       ev[5];
    dvec_t       dv[7];
    dres_t       r;
    logic [38:0] got, w;
    logic [38:0] words[6];
    int          k;
    logic        saw_low;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        ev[0] = '{32'h0, 39'h0,          39'h00_0000_0000};
        ev[1] = '{32'h1, 39'h0,          39'h40_0000_0007};
        ev[2] = '{32'h1, 39'h10,         39'h40_0000_0017};
        ev[3] = '{32'h2, 39'h0,          39'h40_0000_0019};
        ev[4] = '{32'h1, 39'h40_0000_0000, 39'h00_0000_0007};

        dv[0] = '{39'h40_0000_0017, 32'h1,  7'h45, 1'b1, 1'b0};
        dv[1] = '{39'h40_0000_0217, 32'h23, 7'h0F, 1'b0, 1'b1};
        dv[2] = '{39'h40_0000_0007, 32'h1,  7'h00, 1'b0, 1'b0};
        dv[3] = '{39'h00_0000_0007, 32'h1,  7'h40, 1'b1, 1'b0};
        dv[4] = '{39'h40_0000_0006, 32'h1,  7'h41, 1'b1, 1'b0};
        dv[5] = '{39'h00_8000_0081, 32'h0,  7'h69, 1'b0, 1'b1};
        dv[6] = '{39'h00_0000_0000, 32'h0,  7'h00, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enc_out_valid", enc_out_valid, 0);
        chk("rst_dec_out_valid", dec_out_valid, 0);
        chk("rst_enc_cw", enc_cw, 0);
        chk("rst_dec_data", dec_data, 0);
        chk("rst_dec_flags", {dec_syn, dec_err, dec_sgl, dec_dbl}, 0);
        chk("rst_counters", {sgl_cnt, dbl_cnt}, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {enc_ready, dec_ready}, 2'b11);
        cycle();

        for (int i = 0; i < 5; i++) begin
            enc_one(ev[i].d, ev[i].inj, got);
            chk($sformatf("enc_vec%0d", i), got, ev[i].cw);
        end

        for (int i = 0; i < 7; i++) begin
            dec_one(dv[i].cw, r);
            chk($sformatf("dec_vec%0d_data", i), r.d, dv[i].d);
            chk($sformatf("dec_vec%0d_syn", i), r.syn, dv[i].syn);
            chk($sformatf("dec_vec%0d_flags", i), {r.sgl, r.dbl}, {dv[i].sgl, dv[i].dbl});
        end

        // Two injected flips looped back through the decoder must be uncorrectable
        enc_one(32'h1234_5678, (39'h1 << 3) | (39'h1 << 20), got);
        dec_one(got, r);
        chk("loop_dbl", {r.sgl, r.dbl}, 2'b01);
        chk("loop_data_uncorrected", r.d, m_decode(got).d);

        for (int i = 0; i < 6; i++) begin
            w = m_encode($urandom);
            if (i % 2 == 1) w[$urandom_range(0, 38)] ^= 1'b1;
            words[i] = w;
        end
        k = 0; saw_low = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (k >= 6 && dq.size() == 0 && !dec_out_valid) break;
            dec_out_ready = !(c >= 2 && c <= 5);
            dec_valid = (k < 6);
            if (k < 6) dec_cw = words[k];
            #1;
            if (!dec_ready) saw_low = 1'b1;
            if (dec_valid && dec_ready) k++;
            cycle();
        end
        dec_valid = 1'b0; dec_out_ready = 1'b1;
        chk("stall_ready_dropped", saw_low, 1);
        chk("stall_all_accepted", k, 6);
        chk("stall_all_emerged", dq.size(), 0);

        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        #1;
        chk("cnt_clr_zero", {sgl_cnt, dbl_cnt}, 0);
        for (int i = 0; i < 5; i++) dec_one(m_encode($urandom) ^ (39'h1 << $urandom_range(0, 38)), r);
        chk("sgl_cnt_saturated", sgl_cnt, 3);
        dec_cw = m_encode($urandom) ^ (39'h1 << $urandom_range(0, 38));
        dec_valid = 1'b1;
        cycle();
        dec_valid = 1'b0;
        cycle();
        cnt_clr = 1'b1;
        #1;
        chk("clr_inc_out_valid", dec_out_valid, 1);
        cycle();
        cnt_clr = 1'b0;
        #1;
        chk("sgl_cnt_clr_with_inc", sgl_cnt, 1);

        dec_out_ready = 1'b0; enc_out_ready = 1'b0;
        dec_valid = 1'b1; dec_cw = words[0];
        cycle();
        dec_cw = words[1]; enc_valid = 1'b1; enc_data = $urandom; enc_inj = '0;
        cycle();
        dec_valid = 1'b0; enc_valid = 1'b0;
        #1;
        chk("inflight_before_rst", {enc_out_valid, dec_out_valid}, 2'b11);
        rst = 1'b1;
        cycle();
        chk("rst_inflight_valids", {enc_out_valid, dec_out_valid}, 0);
        chk("rst_inflight_counters", {sgl_cnt, dbl_cnt}, 0);
        rst = 1'b0; dec_out_ready = 1'b1; enc_out_ready = 1'b1;
        cycle();
        dec_one(m_encode(32'hCAFE_F00D), r);
        chk("post_rst_data", r.d, 32'hCAFE_F00D);
        chk("post_rst_flags", {r.syn, r.sgl, r.dbl}, 0);

        for (int i = 0; i < 400; i++) begin
            enc_valid = 1'($urandom_range(0, 1));
            enc_data = $urandom;
            enc_inj = ($urandom_range(0, 3) == 0) ? (39'h1 << $urandom_range(0, 38)) : 39'h0;
            enc_out_ready = ($urandom_range(0, 3) != 0);
            w = m_encode($urandom);
            for (int f = $urandom_range(0, 3); f > 0; f--) w[$urandom_range(0, 38)] ^= 1'b1;
            dec_cw = w;
            dec_valid = 1'($urandom_range(0, 1));
            dec_out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end
        enc_valid = 1'b0; dec_valid = 1'b0; cnt_clr = 1'b0;
        enc_out_ready = 1'b1; dec_out_ready = 1'b1;
        repeat (5) cycle();
        chk("drain_enc_queue", eq.size(), 0);
        chk("drain_dec_queue", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
